// File: rtl/hpu_dtcm_pkg.sv
// Shared types for the DTCM SBA responder: SRAM request bundle and starve-counter sizing.
package hpu_dtcm_pkg;

  localparam int unsigned SRAM_DW        = 32;
  localparam int unsigned SRAM_AW        = 14;
  localparam int unsigned DEF_STARVE_LIM = 8;

  function automatic int unsigned starve_cw(input int unsigned lim);
    return $clog2(lim + 1);
  endfunction

  localparam int unsigned STARVE_CW = starve_cw(DEF_STARVE_LIM);

  // Field widths follow the default bus/DTCM geometry of hpu_dtcm_sba_resp
  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [SRAM_AW-1:0]     addr;
    logic [SRAM_DW-1:0]     wdata;
    logic [SRAM_DW/8-1:0]   be;
  } sram_req_t;

endpackage

// File: rtl/hpu_sba_fair_arb.sv
// Core-priority arbiter for the DTCM port; an in-range SBA request that keeps losing wins after STARVE_LIM cycles.
module hpu_sba_fair_arb
  import hpu_dtcm_pkg::*;
#(
  parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic sba_req,
  input  logic sba_clr,
  output logic core_gnt,
  output logic sba_gnt
);

  localparam int unsigned      CntW   = starve_cw(STARVE_LIM);
  localparam logic [CntW-1:0]  LimVal = CntW'(STARVE_LIM);

  logic [CntW-1:0] starve_cnt;
  logic            starved;
  logic            sba_win;

  assign starved  = (starve_cnt == LimVal);
  assign sba_win  = sba_req & (~core_req | starved);
  assign sba_gnt  = sba_win;
  assign core_gnt = core_req & ~sba_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (sba_win | sba_clr) begin
      starve_cnt <= '0;
    end else if (sba_req & core_req & ~starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hpu_dtcm_sba_resp.sv
// Shares the single-port DTCM between the core LSU and debug-module SBA; out-of-range SBA is answered locally.
module hpu_dtcm_sba_resp
  import hpu_dtcm_pkg::*;
#(
  parameter int unsigned          BusWidth   = 32,
  parameter int unsigned          DTCM_AW    = 14,
  parameter logic [BusWidth-1:0]  DTCM_BASE  = 'h0010_0000,
  parameter int unsigned          STARVE_LIM = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dm_dtcm__sba_req_i,
  input  logic [BusWidth-1:0]     dm_dtcm__sba_addr_i,
  input  logic                    dm_dtcm__sba_we_i,
  input  logic [BusWidth-1:0]     dm_dtcm__sba_wdata_i,
  input  logic [BusWidth/8-1:0]   dm_dtcm__sba_be_i,
  output logic                    dtcm_dm__sba_gnt_o,
  output logic [BusWidth-1:0]     dtcm_dm__sba_rdata_o,
  output logic                    dtcm_dm__sba_rdata_act_o,
  input  logic                    lsu_dtcm__req_i,
  input  logic                    lsu_dtcm__we_i,
  input  logic [BusWidth-1:0]     lsu_dtcm__addr_i,
  input  logic [BusWidth-1:0]     lsu_dtcm__wdata_i,
  input  logic [BusWidth/8-1:0]   lsu_dtcm__be_i,
  output logic                    dtcm_lsu__gnt_o,
  output logic                    dtcm_lsu__rdata_act_o,
  output logic [BusWidth-1:0]     dtcm_lsu__rdata_o,
  output logic                    dtcm_ram__en_o,
  output logic                    dtcm_ram__we_o,
  output logic [DTCM_AW-1:0]      dtcm_ram__addr_o,
  output logic [BusWidth-1:0]     dtcm_ram__wdata_o,
  output logic [BusWidth/8-1:0]   dtcm_ram__be_o,
  input  logic [BusWidth-1:0]     ram_dtcm__rdata_i
);

  localparam int unsigned TagLo = DTCM_AW + 2;

  logic      sba_in_range;
  logic      sba_ir_req;
  logic      sba_oor_req;
  logic      lsu_req;
  logic      sba_ir_gnt;
  logic      lsu_gnt;
  logic      rd_sba;
  logic      rd_lsu;
  logic      rd_oor;
  sram_req_t ram_req;
  logic      unused_addr_bits;

  assign sba_in_range = (dm_dtcm__sba_addr_i[BusWidth-1:TagLo] == DTCM_BASE[BusWidth-1:TagLo]);

  // Requests are masked in reset so every grant and RAM strobe reads as zero
  assign sba_ir_req  = ~rst_i & dm_dtcm__sba_req_i &  sba_in_range;
  assign sba_oor_req = ~rst_i & dm_dtcm__sba_req_i & ~sba_in_range;
  assign lsu_req     = ~rst_i & lsu_dtcm__req_i;

  hpu_sba_fair_arb #(
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .clk      (clk_i),
    .rst      (rst_i),
    .core_req (lsu_req),
    .sba_req  (sba_ir_req),
    .sba_clr  (sba_oor_req),
    .core_gnt (lsu_gnt),
    .sba_gnt  (sba_ir_gnt)
  );

  assign dtcm_dm__sba_gnt_o = sba_ir_gnt | sba_oor_req;
  assign dtcm_lsu__gnt_o    = lsu_gnt;

  always_comb begin
    ram_req = '0;
    if (sba_ir_gnt) begin
      ram_req.en    = 1'b1;
      ram_req.we    = dm_dtcm__sba_we_i;
      ram_req.addr  = dm_dtcm__sba_addr_i[DTCM_AW+1:2];
      ram_req.wdata = dm_dtcm__sba_wdata_i;
      ram_req.be    = dm_dtcm__sba_be_i;
    end else if (lsu_gnt) begin
      ram_req.en    = 1'b1;
      ram_req.we    = lsu_dtcm__we_i;
      ram_req.addr  = lsu_dtcm__addr_i[DTCM_AW+1:2];
      ram_req.wdata = lsu_dtcm__wdata_i;
      ram_req.be    = lsu_dtcm__be_i;
    end
  end

  assign dtcm_ram__en_o    = ram_req.en;
  assign dtcm_ram__we_o    = ram_req.we;
  assign dtcm_ram__addr_o  = ram_req.addr;
  assign dtcm_ram__wdata_o = ram_req.wdata;
  assign dtcm_ram__be_o    = ram_req.be;

  // Grant stage -> return stage: tag which requester owns next cycle's read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_sba <= 1'b0;
      rd_lsu <= 1'b0;
      rd_oor <= 1'b0;
    end else begin
      rd_sba <= sba_ir_gnt  & ~dm_dtcm__sba_we_i;
      rd_lsu <= lsu_gnt     & ~lsu_dtcm__we_i;
      rd_oor <= sba_oor_req & ~dm_dtcm__sba_we_i;
    end
  end

  assign dtcm_dm__sba_rdata_act_o = rd_sba | rd_oor;
  assign dtcm_dm__sba_rdata_o     = rd_sba ? ram_dtcm__rdata_i : '0;
  assign dtcm_lsu__rdata_act_o    = rd_lsu;
  assign dtcm_lsu__rdata_o        = rd_lsu ? ram_dtcm__rdata_i : '0;

  // Byte-offset and (for the core, always in range) tag bits carry no information here
  assign unused_addr_bits = ^{dm_dtcm__sba_addr_i[1:0], lsu_dtcm__addr_i[1:0],
                              lsu_dtcm__addr_i[BusWidth-1:TagLo]};

endmodule
